// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, NRD combinational
// read ports, a per-register pending scoreboard and a zero-init sweep after reset.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to
// the read ports (write port 1 has priority over write port 0).
// Register 0 is hardwired to read as zero and is never pending.

module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rpend,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_nxt;
  logic                run;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic [DEPTH-1:0]    pend_nxt;

  logic [ADDR_W-1:0]   ra;
  logic [DATA_W-1:0]   rd;
  logic                rp;

  // State register and sweep index; reset restarts the full zero sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: sweep every entry once, then enter RUN after the last one
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_INIT: begin
        idx_nxt = idx + 1'b1;
        if (&idx) begin
          state_nxt = ST_RUN;
          idx_nxt   = '0;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

  // FSM outputs: ready (and the internal run qualifier) only in RUN
  always_comb begin
    ready = 1'b0;
    run   = 1'b0;
    if (state == ST_RUN) begin
      ready = 1'b1;
      run   = 1'b1;
    end
  end

  // Storage array: zero sweep in INIT, two write ports in RUN (port 1 last so it wins)
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[idx] <= '0;
    end else begin
      if (we0 && (waddr0 != '0)) begin
        mem[waddr0] <= wdata0;
      end
      if (we1 && (waddr1 != '0)) begin
        mem[waddr1] <= wdata1;
      end
    end
  end

  // Scoreboard update: writes clear, issue sets afterwards so a new producer wins
  always_comb begin
    pend_nxt = pend;
    if (run) begin
      if (we0) begin
        pend_nxt[waddr0] = 1'b0;
      end
      if (we1) begin
        pend_nxt[waddr1] = 1'b0;
      end
      if (iss_en) begin
        pend_nxt[iss_addr] = 1'b1;
      end
    end
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard register, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Combinational read ports; disabled ports, r0 and non-RUN states read as zero
  always_comb begin
    rdata = '0;
    rpend = '0;
    ra    = '0;
    rd    = '0;
    rp    = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rd = '0;
      rp = 1'b0;
      if (run && re[i] && (ra != '0)) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (waddr1 == ra)) begin
          rd = wdata1;
        end else if (we0 && (waddr0 == ra)) begin
          rd = wdata0;
        end
`endif
        rp = pend[ra];
      end
      rdata[i*DATA_W +: DATA_W] = rd;
      rpend[i]                  = rp;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the register file and scoreboard.

module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned DEPTH = 32;

  logic                clk;
  logic                rst;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [DW-1:0]       wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [DW-1:0]       wdata1;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rpend;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                ready;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    bit            we0;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] wdata0;
    bit            we1;
    logic [AW-1:0] waddr1;
    logic [DW-1:0] wdata1;
    bit [1:0]      re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    bit            iss;
    logic [AW-1:0] iss_a;
  } stim_t;

  stim_t s;

  // behavioural model: contents, pending flags, cycles since reset release
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  int unsigned   m_cnt;
  bit            m_ready;

  int unsigned   vectors;
  int unsigned   miscompares;
  logic [NRD*DW-1:0] obs_rdata;
  logic [NRD-1:0]    obs_rpend;
  logic              obs_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t.rst = 0; t.we0 = 0; t.waddr0 = '0; t.wdata0 = '0;
    t.we1 = 0; t.waddr1 = '0; t.wdata1 = '0;
    t.re = '0; t.ra0 = '0; t.ra1 = '0; t.iss = 0; t.iss_a = '0;
    return t;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input bit en, input logic [AW-1:0] a);
    if (s.rst || !m_ready || !en || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (s.we1 && s.waddr1 == a) return s.wdata1;
    if (s.we0 && s.waddr0 == a) return s.wdata0;
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_rp(input bit en, input logic [AW-1:0] a);
    if (s.rst || !m_ready || !en || a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  // one clock: drive at negedge, check outputs, then advance the model at posedge
  task automatic cycle();
    logic [AW-1:0] ra [2];
    @(negedge clk);
    rst = s.rst; we0 = s.we0; waddr0 = s.waddr0; wdata0 = s.wdata0;
    we1 = s.we1; waddr1 = s.waddr1; wdata1 = s.wdata1;
    re = s.re; raddr = {s.ra1, s.ra0}; iss_en = s.iss; iss_addr = s.iss_a;
    #1;
    ra[0] = s.ra0; ra[1] = s.ra1;
    check("ready", {63'd0, ready}, {63'd0, (m_ready && !s.rst)});
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rdata%0d[r%0d]", p, ra[p]), {32'd0, rdata[p*DW +: DW]},
            {32'd0, exp_rd(s.re[p], ra[p])});
      check($sformatf("rpend%0d[r%0d]", p, ra[p]), {63'd0, rpend[p]},
            {63'd0, exp_rp(s.re[p], ra[p])});
    end
    obs_rdata = rdata; obs_rpend = rpend; obs_ready = ready;
    @(posedge clk);
    if (s.rst) begin
      m_cnt = 0; m_ready = 0;
      for (int a = 0; a < DEPTH; a++) m_pend[a] = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_ready = 1;
        for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_pend[a] = 0; end
      end
    end else begin
      if (s.we0) m_pend[s.waddr0] = 0;
      if (s.we1) m_pend[s.waddr1] = 0;
      if (s.iss && s.iss_a != 0) m_pend[s.iss_a] = 1;
      if (s.we0 && s.waddr0 != 0) m_mem[s.waddr0] = s.wdata0;
      if (s.we1 && s.waddr1 != 0) m_mem[s.waddr1] = s.wdata1;
    end
  endtask

  // release reset and count how long ready stays low (bounded)
  task automatic sweep_len(input string tag);
    int unsigned low;
    low = 0;
    s = idle();
    s.re = 2'b11; s.ra0 = 5'd4; s.ra1 = 5'd17;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (obs_ready) break;
      low++;
    end
    check(tag, 64'(low), 64'd32);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    m_cnt = 0; m_ready = 0;
    for (int a = 0; a < DEPTH; a++) begin m_mem[a] = 'x; m_pend[a] = 0; end
    rst = 1; we0 = 0; waddr0 = '0; wdata0 = '0; we1 = 0; waddr1 = '0; wdata1 = '0;
    re = '0; raddr = '0; iss_en = 0; iss_addr = '0;

    // reset held, reads attempted: all outputs zero
    s = idle(); s.rst = 1; s.re = 2'b11; s.ra0 = 5'd5; s.ra1 = 5'd9;
    repeat (3) cycle();
    sweep_len("sweep_len_initial");

    // every register reads zero after the sweep
    for (int a = 0; a < DEPTH; a += 2) begin
      s = idle(); s.re = 2'b11; s.ra0 = AW'(a); s.ra1 = AW'(a + 1);
      cycle();
      check("zero_after_sweep", {32'd0, obs_rdata}, 64'd0);
    end

    // write r5, read back next cycle
    s = idle(); s.we0 = 1; s.waddr0 = 5'd5; s.wdata0 = 32'hDEADBEEF; cycle();
    s = idle(); s.re = 2'b01; s.ra0 = 5'd5; cycle();
    check("r5_readback", {32'd0, obs_rdata[DW-1:0]}, 64'hDEADBEEF);
    // write to r0 is discarded
    s = idle(); s.we0 = 1; s.waddr0 = 5'd0; s.wdata0 = 32'h12345678; cycle();
    s = idle(); s.re = 2'b11; s.ra0 = 5'd0; s.ra1 = 5'd5; cycle();
    check("r0_zero", {32'd0, obs_rdata[DW-1:0]}, 64'd0);

    // same-address dual write: port 1 wins
    s = idle(); s.we0 = 1; s.waddr0 = 5'd7; s.wdata0 = 32'h11;
    s.we1 = 1; s.waddr1 = 5'd7; s.wdata1 = 32'h22; cycle();
    s = idle(); s.re = 2'b10; s.ra1 = 5'd7; cycle();
    check("r7_port1_wins", {32'd0, obs_rdata[2*DW-1:DW]}, 64'h22);

    // same-cycle write and read of r9
    s = idle(); s.we1 = 1; s.waddr1 = 5'd9; s.wdata1 = 32'h33; cycle();
    s = idle(); s.we0 = 1; s.waddr0 = 5'd9; s.wdata0 = 32'h55; s.re = 2'b01; s.ra0 = 5'd9; cycle();
`ifdef REGFILE_BYPASS_EN
    check("r9_same_cycle", {32'd0, obs_rdata[DW-1:0]}, 64'h55);
`else
    check("r9_same_cycle", {32'd0, obs_rdata[DW-1:0]}, 64'h33);
`endif
    s = idle(); s.re = 2'b01; s.ra0 = 5'd9; cycle();
    check("r9_next_cycle", {32'd0, obs_rdata[DW-1:0]}, 64'h55);

    // scoreboard: issue sets, set beats clear, lone write clears
    s = idle(); s.iss = 1; s.iss_a = 5'd3; s.re = 2'b01; s.ra0 = 5'd3; cycle();
    check("r3_pend_not_forwarded", {63'd0, obs_rpend[0]}, 64'd0);
    s = idle(); s.re = 2'b01; s.ra0 = 5'd3; cycle();
    check("r3_pend_set", {63'd0, obs_rpend[0]}, 64'd1);
    s = idle(); s.we0 = 1; s.waddr0 = 5'd3; s.wdata0 = 32'hA; s.iss = 1; s.iss_a = 5'd3; cycle();
    s = idle(); s.re = 2'b01; s.ra0 = 5'd3; cycle();
    check("r3_set_beats_clear", {63'd0, obs_rpend[0]}, 64'd1);
    s = idle(); s.we1 = 1; s.waddr1 = 5'd3; s.wdata1 = 32'hB; cycle();
    s = idle(); s.re = 2'b01; s.ra0 = 5'd3; cycle();
    check("r3_cleared", {63'd0, obs_rpend[0]}, 64'd0);
    // issue to r0 never makes it pending
    s = idle(); s.iss = 1; s.iss_a = 5'd0; cycle();
    s = idle(); s.re = 2'b01; s.ra0 = 5'd0; cycle();

    // reset mid-sweep at index 10, then a full sweep again
    s = idle(); s.rst = 1; cycle();
    s = idle();
    repeat (10) cycle();
    s = idle(); s.rst = 1; s.re = 2'b11; s.ra0 = 5'd5; s.ra1 = 5'd7;
    repeat (2) cycle();
    check("ready_low_in_reset", {63'd0, obs_ready}, 64'd0);
    sweep_len("sweep_len_restart");

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 249) == 0);
      s.we0 = $urandom_range(0, 1); s.waddr0 = rnd_addr(); s.wdata0 = $urandom;
      s.we1 = $urandom_range(0, 1); s.waddr1 = rnd_addr(); s.wdata1 = $urandom;
      s.re = 2'($urandom_range(0, 3)); s.ra0 = rnd_addr(); s.ra1 = rnd_addr();
      s.iss = ($urandom_range(0, 2) == 0); s.iss_a = rnd_addr();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
